// File: rtl/pci_pkg.sv
// pci_pkg: shared command codes, address field widths and target FSM states
package pci_pkg;
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    localparam int ADDR_W   = 2;
    localparam int WORD_LSB = 2;
    localparam int TAG_LSB  = WORD_LSB + ADDR_W;
    typedef enum logic [2:0] {IDLE, WR_DATA, RD_TURN, RD_DATA, STOP, BUS_WAIT} state_t;
endpackage

// File: rtl/pci_target_decode.sv
// pci_target_decode: address-phase window hit and memory command check
module pci_target_decode
    import pci_pkg::*;
#(
    parameter logic [31:0] BAR_BASE = 32'h0000_1000
) (
    input  logic [31-TAG_LSB:0] ad_tag,
    input  logic [3:0]          cbe_n,
    output logic                hit,
    output logic                is_read,
    output logic                is_write
);
    assign hit      = ad_tag == BAR_BASE[31:TAG_LSB];
    assign is_read  = cbe_n == CMD_MEM_RD;
    assign is_write = cbe_n == CMD_MEM_WR;
endmodule

// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl: PCI target handshake FSM driving a small word-addressed store
module pci_target_ctrl
    import pci_pkg::*;
#(
    parameter logic [31:0] BAR_BASE = 32'h0000_1000,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_n,
    input  logic              irdy_n,
    input  logic [3:0]        cbe_n,
    input  logic [31:0]       ad_in,
    output logic              devsel_n,
    output logic              trdy_n,
    output logic              stop_n,
    output logic              ad_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [3:0]        mem_be,
    output logic              busy
);
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic single, single_nx, hit, is_read, is_write, last;

    pci_target_decode #(.BAR_BASE(BAR_BASE)) u_decode (
        .ad_tag   (ad_in[31:TAG_LSB]),
        .cbe_n    (cbe_n),
        .hit      (hit),
        .is_read  (is_read),
        .is_write (is_write)
    );

    assign last   = mem_addr == ADDR_W'(DEPTH - 1);
    assign mem_be = ~cbe_n;
    // strobes are suppressed while reset is held so no access slips out on the reset edge
    assign mem_we = rst_n && state == WR_DATA && !irdy_n;
    assign mem_re = rst_n && state == RD_DATA && !irdy_n;

    // next state, burst address advance and single-phase flag
    always_comb begin
        state_nx  = state;
        addr_nx   = mem_addr;
        single_nx = single;
        case (state)
            IDLE: if (!frame_n) begin
                addr_nx   = ad_in[TAG_LSB-1:WORD_LSB];
                single_nx = |ad_in[WORD_LSB-1:0];
                state_nx  = !hit ? BUS_WAIT : is_write ? WR_DATA : is_read ? RD_TURN : BUS_WAIT;
            end
            RD_TURN: state_nx = RD_DATA;
            WR_DATA, RD_DATA: if (!irdy_n) begin
                if (frame_n) state_nx = IDLE;
                else if (last || single) state_nx = STOP;
                else addr_nx = mem_addr + 1'b1;
            end
            STOP: if (frame_n) state_nx = IDLE;
            BUS_WAIT: if (frame_n && irdy_n) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, address and registered PCI control outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            single   <= 1'b0;
            devsel_n <= 1'b1;
            trdy_n   <= 1'b1;
            stop_n   <= 1'b1;
            ad_oe    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_addr <= addr_nx;
            single   <= single_nx;
            devsel_n <= !(state_nx inside {WR_DATA, RD_TURN, RD_DATA, STOP});
            trdy_n   <= !(state_nx inside {WR_DATA, RD_DATA});
            stop_n   <= state_nx != STOP;
            ad_oe    <= state_nx inside {RD_TURN, RD_DATA};
            busy     <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb_pci_target_ctrl: directed bus-cycle vectors against hand-computed target responses
module tb_pci_target_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, frame_n, irdy_n;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    logic        devsel_n, trdy_n, stop_n, ad_oe, mem_we, mem_re, busy;
    logic [1:0]  mem_addr;
    logic [3:0]  mem_be;
    int vectors = 0;
    int miscompares = 0;

    pci_target_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .cbe_n    (cbe_n),
        .ad_in    (ad_in),
        .devsel_n (devsel_n),
        .trdy_n   (trdy_n),
        .stop_n   (stop_n),
        .ad_oe    (ad_oe),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_be   (mem_be),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic f, input logic i, input logic [3:0] c, input logic [31:0] a);
        frame_n = f;
        irdy_n  = i;
        cbe_n   = c;
        ad_in   = a;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 4'hF, 32'h0);
        repeat (3) tick;
        rst_n = 1'b1;
        chk("rst_devsel", 32'(devsel_n), 1);
        chk("rst_trdy", 32'(trdy_n), 1);
        chk("rst_stop", 32'(stop_n), 1);
        chk("rst_ad_oe", 32'(ad_oe), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(busy), 0);

        drive(0, 1, 4'b0111, 32'h1000);
        chk("wr_addr_busy", 32'(busy), 0);
        chk("wr_addr_we", 32'(mem_we), 0);
        tick;
        drive(0, 0, 4'b0000, 32'hAAAA_0000);
        chk("wr1_devsel", 32'(devsel_n), 0);
        chk("wr1_trdy", 32'(trdy_n), 0);
        chk("wr1_we", 32'(mem_we), 1);
        chk("wr1_addr", 32'(mem_addr), 0);
        chk("wr1_be", 32'(mem_be), 4'hF);
        tick;
        drive(0, 0, 4'b1010, 32'hAAAA_0001);
        chk("wr2_we", 32'(mem_we), 1);
        chk("wr2_addr", 32'(mem_addr), 1);
        chk("wr2_be", 32'(mem_be), 4'h5);
        tick;
        drive(1, 0, 4'b0000, 32'hAAAA_0002);
        chk("wr3_we", 32'(mem_we), 1);
        chk("wr3_addr", 32'(mem_addr), 2);
        chk("wr3_stop", 32'(stop_n), 1);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        chk("wr_end_devsel", 32'(devsel_n), 1);
        chk("wr_end_trdy", 32'(trdy_n), 1);
        chk("wr_end_busy", 32'(busy), 0);
        chk("wr_end_we", 32'(mem_we), 0);

        drive(0, 1, 4'b0110, 32'h1008);
        tick;
        drive(0, 1, 4'b0000, 32'h0);
        chk("rd_turn_devsel", 32'(devsel_n), 0);
        chk("rd_turn_trdy", 32'(trdy_n), 1);
        chk("rd_turn_oe", 32'(ad_oe), 1);
        chk("rd_turn_re", 32'(mem_re), 0);
        tick;
        drive(0, 1, 4'b0000, 32'h0);
        chk("rd_w1_trdy", 32'(trdy_n), 0);
        chk("rd_w1_re", 32'(mem_re), 0);
        tick;
        drive(0, 1, 4'b0000, 32'h0);
        chk("rd_w2_re", 32'(mem_re), 0);
        chk("rd_w2_addr", 32'(mem_addr), 2);
        tick;
        drive(1, 0, 4'b0000, 32'h0);
        chk("rd_done_re", 32'(mem_re), 1);
        chk("rd_done_addr", 32'(mem_addr), 2);
        chk("rd_done_oe", 32'(ad_oe), 1);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        chk("rd_end_oe", 32'(ad_oe), 0);
        chk("rd_end_devsel", 32'(devsel_n), 1);
        chk("rd_end_re", 32'(mem_re), 0);

        drive(0, 1, 4'b0111, 32'h100C);
        tick;
        drive(0, 0, 4'b0000, 32'h5);
        chk("disc_we", 32'(mem_we), 1);
        chk("disc_addr", 32'(mem_addr), 3);
        tick;
        drive(0, 0, 4'b0000, 32'h6);
        chk("disc_stop", 32'(stop_n), 0);
        chk("disc_trdy", 32'(trdy_n), 1);
        chk("disc_devsel", 32'(devsel_n), 0);
        chk("disc_we_off", 32'(mem_we), 0);
        chk("disc_addr_hold", 32'(mem_addr), 3);
        tick;
        drive(1, 0, 4'b0000, 32'h0);
        chk("disc_stop_hold", 32'(stop_n), 0);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        chk("disc_end_stop", 32'(stop_n), 1);
        chk("disc_end_busy", 32'(busy), 0);

        drive(0, 1, 4'b0110, 32'h2000);
        tick;
        drive(0, 0, 4'b0000, 32'h0);
        chk("miss_devsel", 32'(devsel_n), 1);
        chk("miss_busy", 32'(busy), 1);
        chk("miss_re", 32'(mem_re), 0);
        tick;
        drive(1, 0, 4'b0000, 32'h0);
        chk("miss_busy2", 32'(busy), 1);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        chk("miss_busy3", 32'(busy), 1);
        chk("miss_trdy", 32'(trdy_n), 1);
        tick;
        chk("miss_end_busy", 32'(busy), 0);

        drive(0, 1, 4'b0010, 32'h1000);
        tick;
        drive(0, 0, 4'b0000, 32'h0);
        chk("cmd_devsel", 32'(devsel_n), 1);
        chk("cmd_we", 32'(mem_we), 0);
        chk("cmd_re", 32'(mem_re), 0);
        chk("cmd_busy", 32'(busy), 1);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        chk("cmd_busy2", 32'(busy), 1);
        tick;
        chk("cmd_end_busy", 32'(busy), 0);

        drive(0, 1, 4'b0111, 32'h1000);
        tick;
        drive(0, 0, 4'b0000, 32'h1);
        chk("rstw_we", 32'(mem_we), 1);
        tick;
        chk("rstw_addr1", 32'(mem_addr), 1);
        rst_n = 1'b0;
        drive(0, 0, 4'b0000, 32'h2);
        tick;
        drive(0, 0, 4'b0000, 32'h3);
        chk("rstw_devsel", 32'(devsel_n), 1);
        chk("rstw_trdy", 32'(trdy_n), 1);
        chk("rstw_addr", 32'(mem_addr), 0);
        chk("rstw_we_off", 32'(mem_we), 0);
        chk("rstw_busy", 32'(busy), 0);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        rst_n = 1'b1;
        tick;
        chk("rstw_after_we", 32'(mem_we), 0);
        chk("rstw_after_busy", 32'(busy), 0);

        drive(0, 1, 4'b0110, 32'h1001);
        tick;
        drive(0, 0, 4'b0000, 32'h0);
        chk("sgl_turn_trdy", 32'(trdy_n), 1);
        chk("sgl_turn_re", 32'(mem_re), 0);
        tick;
        drive(0, 0, 4'b0000, 32'h0);
        chk("sgl_re", 32'(mem_re), 1);
        chk("sgl_addr", 32'(mem_addr), 0);
        tick;
        drive(0, 0, 4'b0000, 32'h0);
        chk("sgl_stop", 32'(stop_n), 0);
        chk("sgl_oe", 32'(ad_oe), 0);
        chk("sgl_re_off", 32'(mem_re), 0);
        tick;
        drive(1, 1, 4'hF, 32'h0);
        chk("sgl_stop_hold", 32'(stop_n), 0);
        tick;
        chk("sgl_end_stop", 32'(stop_n), 1);
        chk("sgl_end_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
